// File: rtl/pipelined_control_unit.sv
// RV32I control unit with ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall detection and branch-flush bubbling.
module pipelined_control_unit #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter bit          LOAD_USE_DET = 1'b1,
  parameter bit          ILLEGAL_NOP  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [6:0]            opcode,
  input  logic [2:0]            func3,
  input  logic                  func7,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_flush,
  output logic                  stall,
  output logic                  illegal,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic [1:0]            ex_alu_op,
  output logic [3:0]            ex_alu_ctrl,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_mem_to_reg,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluXor  = 4'b0011;
  localparam logic [3:0] AluSll  = 4'b0100;
  localparam logic [3:0] AluSrl  = 4'b0101;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluSltu = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  alu_src;
    logic                  branch;
    logic [1:0]            alu_op;
    logic [3:0]            alu_ctrl;
    logic [REG_ADDR_W-1:0] rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } wb_ctrl_t;

  function automatic ex_ctrl_t bubble();
    ex_ctrl_t b;
    b          = '0;
    b.alu_ctrl = AluAdd;
    return b;
  endfunction

  // f7 selects SUB only at f3=000 and SRA only at f3=101; callers pre-gate it.
  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic f7);
    logic [3:0] fn;
    case (f3)
      3'b000:  fn = f7 ? AluSub : AluAdd;
      3'b001:  fn = AluSll;
      3'b010:  fn = AluSlt;
      3'b011:  fn = AluSltu;
      3'b100:  fn = AluXor;
      3'b101:  fn = f7 ? AluSra : AluSrl;
      3'b110:  fn = AluOr;
      default: fn = AluAnd;
    endcase
    return fn;
  endfunction

  ex_ctrl_t  dec, ex_d, ex_q;
  mem_ctrl_t mem_d, mem_q;
  wb_ctrl_t  wb_d, wb_q;
  logic      legal, uses_rs1, uses_rs2, hazard;

  always_comb begin
    dec      = bubble();
    legal    = 1'b1;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OpR: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
        dec.alu_ctrl  = alu_fn(func3, func7);
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OpI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = 2'b11;
        dec.alu_ctrl  = alu_fn(func3, func7 & (func3 == 3'b101));
        uses_rs1      = 1'b1;
      end
      OpLoad: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        uses_rs1       = 1'b1;
      end
      OpStore: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OpBranch: begin
        dec.branch   = 1'b1;
        dec.alu_op   = 2'b01;
        dec.alu_ctrl = AluSub;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (legal) dec.rd = id_rd;
    if (dec.rd == '0) dec.reg_write = 1'b0;
  end

  always_comb begin
    hazard = ex_q.mem_read && (ex_q.rd != '0) &&
             ((uses_rs1 && (ex_q.rd == id_rs1)) || (uses_rs2 && (ex_q.rd == id_rs2)));
    // A flush kills the ID instruction, so a stall would only delay the redirect.
    stall   = LOAD_USE_DET && id_valid && !ex_flush && hazard;
    illegal = ILLEGAL_NOP && id_valid && !legal;
    ex_d    = (id_valid && !ex_flush && !stall) ? dec : bubble();
    mem_d   = '{reg_write: ex_q.reg_write, mem_read: ex_q.mem_read, mem_write: ex_q.mem_write,
                mem_to_reg: ex_q.mem_to_reg, rd: ex_q.rd};
    wb_d    = '{reg_write: mem_q.reg_write, mem_to_reg: mem_q.mem_to_reg, rd: mem_q.rd};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= bubble();
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_reg_write   = ex_q.reg_write;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_mem_to_reg  = ex_q.mem_to_reg;
  assign ex_alu_src     = ex_q.alu_src;
  assign ex_branch      = ex_q.branch;
  assign ex_alu_op      = ex_q.alu_op;
  assign ex_alu_ctrl    = ex_q.alu_ctrl;
  assign ex_rd          = ex_q.rd;
  assign mem_reg_write  = mem_q.reg_write;
  assign mem_mem_read   = mem_q.mem_read;
  assign mem_mem_write  = mem_q.mem_write;
  assign mem_mem_to_reg = mem_q.mem_to_reg;
  assign mem_rd         = mem_q.rd;
  assign wb_reg_write   = wb_q.reg_write;
  assign wb_mem_to_reg  = wb_q.mem_to_reg;
  assign wb_rd          = wb_q.rd;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench: directed scenarios plus random instruction stream against
// a table-driven reference model of the decode/hazard/pipeline rules.
module tb_pipelined_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, func7, ex_flush;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall, illegal;
  logic       ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch;
  logic [1:0] ex_alu_op;
  logic [3:0] ex_alu_ctrl;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic       wb_reg_write, wb_mem_to_reg;

  pipelined_control_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .func3(func3),
    .func7(func7), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_flush(ex_flush),
    .stall(stall), .illegal(illegal), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
    .ex_branch(ex_branch), .ex_alu_op(ex_alu_op), .ex_alu_ctrl(ex_alu_ctrl), .ex_rd(ex_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_rd(mem_rd), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OpR = 7'h33, OpI = 7'h13, OpLd = 7'h03, OpSt = 7'h23, OpBr = 7'h63;

  typedef struct packed {
    logic       rw, mr, mw, m2r, src, br;
    logic [1:0] op;
    logic [3:0] ctrl;
    logic [4:0] rd;
  } ctl_t;

  int   n_checks = 0;
  int   n_errors = 0;
  ctl_t ex_m, mem_m, wb_m;
  logic obs_stall, obs_ill, exp_stall_last;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t ref_bubble();
    ctl_t c = '0;
    c.ctrl = 4'b0010;
    return c;
  endfunction

  function automatic bit ref_legal(input logic [6:0] opc);
    return opc inside {OpR, OpI, OpLd, OpSt, OpBr};
  endfunction

  // Flags {rw,mr,mw,m2r,src,br} and alu_op straight from the instruction-class table.
  function automatic ctl_t ref_decode(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic f7, input logic [4:0] rd);
    logic [3:0] fn_tab [8];
    ctl_t c;
    fn_tab = '{4'b0010, 4'b0100, 4'b0111, 4'b1000, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
    c = ref_bubble();
    if (!ref_legal(opc)) return c;
    case (opc)
      OpR:     {c.rw, c.mr, c.mw, c.m2r, c.src, c.br, c.op} = 8'b100000_10;
      OpI:     {c.rw, c.mr, c.mw, c.m2r, c.src, c.br, c.op} = 8'b100010_11;
      OpLd:    {c.rw, c.mr, c.mw, c.m2r, c.src, c.br, c.op} = 8'b110110_00;
      OpSt:    {c.rw, c.mr, c.mw, c.m2r, c.src, c.br, c.op} = 8'b001010_00;
      default: {c.rw, c.mr, c.mw, c.m2r, c.src, c.br, c.op} = 8'b000001_01;
    endcase
    if (c.op == 2'b01) c.ctrl = 4'b0110;
    if (c.op[1]) begin
      c.ctrl = fn_tab[f3];
      if (f3 == 3'd5 && f7) c.ctrl = 4'b1001;
      if (c.op == 2'b10 && f3 == 3'd0 && f7) c.ctrl = 4'b0110;
    end
    c.rd = rd;
    if (rd == 5'd0) c.rw = 1'b0;
    return c;
  endfunction

  function automatic logic ref_stall(input logic v, input logic fl, input logic [6:0] opc,
                                     input logic [4:0] r1, input logic [4:0] r2);
    bit u1 = opc inside {OpR, OpI, OpLd, OpSt, OpBr};
    bit u2 = opc inside {OpR, OpSt, OpBr};
    return v && !fl && ex_m.mr && ex_m.rd != 0 &&
           ((u1 && ex_m.rd == r1) || (u2 && ex_m.rd == r2));
  endfunction

  function automatic logic [16:0] ex_vec();
    return {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch,
            ex_alu_op, ex_alu_ctrl, ex_rd};
  endfunction

  function automatic logic [8:0] mem_vec_of(input ctl_t c);
    return {c.rw, c.mr, c.mw, c.m2r, c.rd};
  endfunction

  function automatic logic [6:0] wb_vec_of(input ctl_t c);
    return {c.rw, c.m2r, c.rd};
  endfunction

  // One clock: drive ID, check comb outputs, clock, advance model, check stage registers.
  task automatic step(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                      input logic f7, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic fl);
    logic es, ei;
    id_valid = v; opcode = opc; func3 = f3; func7 = f7;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd; ex_flush = fl;
    #1;
    es = ref_stall(v, fl, opc, r1, r2);
    ei = v && !ref_legal(opc);
    check_eq("stall", 32'(stall), 32'(es));
    check_eq("illegal", 32'(illegal), 32'(ei));
    obs_stall = stall;
    obs_ill = illegal;
    exp_stall_last = es;
    @(posedge clk);
    wb_m  = mem_m;
    mem_m = ex_m;
    ex_m  = (v && !fl && !es) ? ref_decode(opc, f3, f7, rd) : ref_bubble();
    #1;
    check_eq("ex_stage", 32'(ex_vec()), 32'(ex_m));
    check_eq("mem_stage", 32'({mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
                                mem_rd}), 32'(mem_vec_of(mem_m)));
    check_eq("wb_stage", 32'({wb_reg_write, wb_mem_to_reg, wb_rd}), 32'(wb_vec_of(wb_m)));
  endtask

  task automatic model_reset();
    ex_m = ref_bubble(); mem_m = ref_bubble(); wb_m = ref_bubble();
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ex"}, 32'(ex_vec()), 32'(17'h00040));
    check_eq({tag, "_mem"}, 32'({mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
                                 mem_rd}), 32'd0);
    check_eq({tag, "_wb"}, 32'({wb_reg_write, wb_mem_to_reg, wb_rd}), 32'd0);
  endtask

  initial begin
    logic       v, fl, f7;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [4:0] r1, r2, rd;
    logic [6:0] op_tab [7];

    reset = 1'b1;
    id_valid = 0; opcode = 0; func3 = 0; func7 = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_flush = 0;
    model_reset();
    @(posedge clk); #1;
    check_reset_state("reset");
    check_eq("reset_stall", 32'(stall), 32'd0);
    reset = 1'b0;

    // R-type SUB to x5, then follow it down to WB.
    step(1, OpR, 3'd0, 1, 5'd1, 5'd2, 5'd5, 0);
    check_eq("sub_ctrl", 32'(ex_alu_ctrl), 32'h6);
    check_eq("sub_rw", 32'(ex_reg_write), 32'd1);
    step(0, 7'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 7'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 0);
    check_eq("sub_wb_rd", 32'(wb_rd), 32'd5);

    // LW x3 then ADD x4,x3,x1: one stall, then ADD proceeds.
    step(1, OpLd, 3'd2, 0, 5'd1, 5'd0, 5'd3, 0);
    step(1, OpR, 3'd0, 0, 5'd3, 5'd1, 5'd4, 0);
    check_eq("lu_stall", 32'(obs_stall), 32'd1);
    check_eq("lu_bubble", 32'(ex_vec()), 32'(17'h00040));
    step(1, OpR, 3'd0, 0, 5'd3, 5'd1, 5'd4, 0);
    check_eq("lu_release", 32'(obs_stall), 32'd0);
    check_eq("lu_add_rd", 32'(ex_rd), 32'd4);

    // LW x0 never causes a stall nor a write.
    step(1, OpLd, 3'd2, 0, 5'd1, 5'd0, 5'd0, 0);
    check_eq("lw_x0_rw", 32'(ex_reg_write), 32'd0);
    step(1, OpR, 3'd0, 0, 5'd0, 5'd1, 5'd4, 0);
    check_eq("lw_x0_stall", 32'(obs_stall), 32'd0);

    // Flush beats a pending load-use stall.
    step(1, OpLd, 3'd2, 0, 5'd1, 5'd0, 5'd3, 0);
    step(1, OpR, 3'd0, 0, 5'd3, 5'd1, 5'd4, 1);
    check_eq("flush_stall", 32'(obs_stall), 32'd0);
    check_eq("flush_ill", 32'(obs_ill), 32'd0);
    check_eq("flush_bubble", 32'(ex_vec()), 32'(17'h00040));

    // Illegal opcode, SRAI, ADDI with f7 set.
    step(1, 7'h7F, 3'd0, 0, 5'd1, 5'd2, 5'd3, 0);
    check_eq("ill_flag", 32'(obs_ill), 32'd1);
    check_eq("ill_bubble", 32'(ex_vec()), 32'(17'h00040));
    step(1, OpI, 3'd5, 1, 5'd1, 5'd0, 5'd2, 0);
    check_eq("srai_ctrl", 32'(ex_alu_ctrl), 32'h9);
    step(1, OpI, 3'd0, 1, 5'd1, 5'd0, 5'd2, 0);
    check_eq("addi_ctrl", 32'(ex_alu_ctrl), 32'h2);

    // Random stream; a stalled instruction is re-presented until it issues.
    op_tab = '{OpR, OpI, OpLd, OpSt, OpBr, 7'h7F, 7'h00};
    v = 0; opc = 0; f3 = 0; f7 = 0; r1 = 0; r2 = 0; rd = 0;
    for (int i = 0; i < 600; i++) begin
      if (!(exp_stall_last && v)) begin
        v   = ($urandom_range(0, 9) != 0);
        opc = op_tab[$urandom_range(0, 6)];
        if (opc == 7'h00) opc = 7'($urandom);
        f3  = 3'($urandom);
        f7  = 1'($urandom);
        r1  = 5'($urandom_range(0, 3));
        r2  = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
      end
      fl = ($urandom_range(0, 9) == 0);
      step(v, opc, f3, f7, r1, r2, rd, fl);
    end

    // Async reset mid-stall: state cleared at once, pending load forgotten.
    step(1, OpLd, 3'd2, 0, 5'd1, 5'd0, 5'd3, 0);
    step(1, OpR, 3'd0, 0, 5'd3, 5'd1, 5'd4, 0);
    id_valid = 1; opcode = OpLd; id_rd = 5'd3;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    check_reset_state("mid_reset");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    step(1, OpR, 3'd0, 0, 5'd3, 5'd1, 5'd4, 0);
    check_eq("post_reset_stall", 32'(obs_stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
